tcdm_bank_arbiter: RTL and testbench
====================================

# tcdm_bank_arbiter

Shares one single-ported TCDM SRAM bank (1-cycle read latency) between `NumInp` requesters, such as the local cores of a tile and the remote-group ports. It performs round-robin arbitration and drives the bank. Read responses are returned through a 2-entry response buffer, and responses are credit-limited so no read data is ever dropped. Writes are posted and produce no response, matching TCDM semantics.

## Interface
- `NumInp`, 4: number of requesters, ≥2.
- `DataWidth`, 32: data word width.
- `BeWidth`, `DataWidth/8`: byte-enable width.
- `AddrMemWidth`, 8: bank word-address width (1 KiB bank / 4 B).
- `MetaWidth`, 8: opaque per-request tag (meta_id + core_id); returned unchanged with the read data.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in `NumInp`: request valid, one bit per requester.
- `req_ready_o` out `NumInp`: grant, one-hot or zero.
- `req_wen_i` in `NumInp`: 1 = write, 0 = read.
- `req_addr_i` in `NumInp*AddrMemWidth`: bank word address per requester.
- `req_be_i` in `NumInp*BeWidth`: byte enables per requester.
- `req_wdata_i` in `NumInp*DataWidth`: write data per requester.
- `req_meta_i` in `NumInp*MetaWidth`: tag per requester.
- `resp_valid_o` out `NumInp`: read response valid, one-hot or zero.
- `resp_ready_i` in `NumInp`: response ready per requester.
- `resp_rdata_o` out `DataWidth`: response data, shared by all requesters.
- `resp_meta_o` out `MetaWidth`: response tag, shared by all requesters.
- `bank_req_o` out 1: SRAM access strobe.
- `bank_we_o` out 1: SRAM write enable.
- `bank_addr_o` out `AddrMemWidth`: SRAM word address.
- `bank_be_o` out `BeWidth`: SRAM byte enables.
- `bank_wdata_o` out `DataWidth`: SRAM write data.
- `bank_rdata_i` in `DataWidth`: SRAM read data, valid the cycle after a read strobe.

## Operation
- **State**
  - `rr_ptr`: priority pointer, range 0..NumInp-1.
  - Stage-1 register `s1` (valid, requester index, meta): tracks a read issued last cycle.
  - 2-entry response FIFO: each entry holds data, meta and index.
- **Credit**
  - `inflight` = `s1.valid` + FIFO count.
  - `pop` = `resp_valid_o[head.idx] & resp_ready_i[head.idx]`.
  - `rd_ok` = (`inflight` − `pop`) < 2.
- **Eligibility**: requester i is eligible iff `req_valid_i[i]` is high and (`req_wen_i[i]` or `rd_ok`).
- **Grant**
  - The first eligible requester scanning i = `rr_ptr`, `rr_ptr`+1, … mod `NumInp` is granted.
  - `req_ready_o[i]` = 1 for the granted requester only.
  - Grant is combinational from inputs and state.
- **On a grant**
  - `bank_req_o` = 1 and `bank_*` carry the granted requester's fields. `bank_we_o` = `req_wen_i[i]`.
  - `rr_ptr` ← (i+1) mod `NumInp`.
  - For a read, `s1` ← {1, i, meta}. For a write, `s1.valid` ← 0.
- **No grant**: `bank_req_o` = 0, `rr_ptr` holds, `s1.valid` ← 0.
- **Capture**: when `s1.valid` is set, the FIFO pushes {`bank_rdata_i`, `s1.meta`, `s1.idx`}. The credit rule guarantees a free slot, counting a same-cycle pop.
- **Response output**
  - While the FIFO is non-empty, `resp_valid_o` = one-hot(`head.idx`) and `resp_rdata_o`/`resp_meta_o` = head fields.
  - The head pops on the `resp_ready_i` handshake.
  - Responses return in issue order. A stalled head blocks later responses (head-of-line blocking, by design).
  - Once `resp_valid_o` is asserted, the response is held stable until it is accepted.
- **Writes**: never consume credit and are never blocked by response backpressure.
- **Arbitration scope**: the request payload is only sampled on grant. Requesters hold the payload until `req_ready_o`.

## Timing
- **Reset values**
  - `rr_ptr` = 0, `s1.valid` = 0, FIFO empty.
  - During reset, `req_ready_o` = 0, `resp_valid_o` = 0 and `bank_req_o` = 0.
  - `bank_we_o`, `bank_addr_o`, `bank_be_o`, `bank_wdata_o`, `resp_rdata_o` and `resp_meta_o` are 0.
- **Read latency**: read granted in cycle t → SRAM data at t+1 → `resp_valid_o` at t+2, earliest.
- **Write latency**: write granted in cycle t → SRAM written at the clock edge ending t.
- **Throughput**: 1 access per cycle. Back-to-back reads sustain 1 response per cycle while the head ready stays high.
- **Credit exhaustion**: with `resp_ready_i` low, at most 2 reads are accepted (1 in `s1` plus 1 in the FIFO, then 2 in the FIFO). Further reads see `req_ready_o` = 0. Writes still proceed.
- **Simultaneous pop and issue**: when the FIFO is full and the head pops in the same cycle, a new read may be granted.
- **Reset mid-operation**: in-flight reads and buffered responses are discarded and `rr_ptr` returns to 0.

## Test plan
- **Single read**: requester 2 reads addr 0x10, SRAM returns 0xCAFE0001 → `req_ready_o` = 0b0100 in cycle t. At t+2, `resp_valid_o` = 0b0100, `resp_rdata_o` = 0xCAFE0001, meta echoed.
- **Round-robin fairness**: all 4 requesters hold reads for 8 cycles with ready high → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, one per cycle, from t+2.
- **Response backpressure**: requesters 0 and 1 read continuously with `resp_ready_i` = 0 → exactly 2 grants, then `req_ready_o` = 0. Releasing ready drains 2 responses and reads resume the cycle of the first pop.
- **Writes under full credit**: FIFO full, requester 3 writes 0xDEAD_BEEF with be=0xF to addr 0x05 → granted immediately, `bank_we_o` = 1, no `resp_valid_o` for requester 3. A later read of 0x05 returns 0xDEADBEEF.
- **Mixed contention**: requester 0 reads and requester 1 writes in the same cycle with `rr_ptr` = 1 → requester 1 is granted first, requester 0 the next cycle, and `rr_ptr` ends at 1.
- **Reset mid-operation**: assert `rst_i` with 2 responses buffered → `resp_valid_o` = 0 immediately, and no stale response appears after release. The first grant after reset goes to the lowest-index valid requester.

Source files
------------

// File: rtl/tcdm_bank_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for the TCDM bank arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the SRAM macro.
interface tcdm_bank_arbiter_if #(
  parameter int unsigned NumInp       = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 8,
  parameter int unsigned MetaWidth    = 8
);
  logic [NumInp-1:0]              req_valid;
  logic [NumInp-1:0]              req_ready;
  logic [NumInp-1:0]              req_wen;
  logic [NumInp*AddrMemWidth-1:0] req_addr;
  logic [NumInp*BeWidth-1:0]      req_be;
  logic [NumInp*DataWidth-1:0]    req_wdata;
  logic [NumInp*MetaWidth-1:0]    req_meta;
  logic [NumInp-1:0]              resp_valid;
  logic [NumInp-1:0]              resp_ready;
  logic [DataWidth-1:0]           resp_rdata;
  logic [MetaWidth-1:0]           resp_meta;
  logic                           bank_req;
  logic                           bank_we;
  logic [AddrMemWidth-1:0]        bank_addr;
  logic [BeWidth-1:0]             bank_be;
  logic [DataWidth-1:0]           bank_wdata;
  logic [DataWidth-1:0]           bank_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_be, req_wdata, req_meta, resp_ready, bank_rdata,
    output req_ready, resp_valid, resp_rdata, resp_meta,
    output bank_req, bank_we, bank_addr, bank_be, bank_wdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_be, req_wdata, req_meta, resp_ready, bank_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_meta,
    input  bank_req, bank_we, bank_addr, bank_be, bank_wdata
  );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter in front of one single-ported TCDM bank (1-cycle read latency).
// Reads return through a 2-entry response FIFO; read grants are credit-limited so the
// FIFO can never overflow. Writes are posted and bypass the credit check.
module tcdm_bank_arbiter #(
  parameter int unsigned NumInp       = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 8,
  parameter int unsigned MetaWidth    = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  tcdm_bank_arbiter_if.slave bus
);
  localparam int unsigned IdxWidth = $clog2(NumInp);

  logic [IdxWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 s1_valid_q;
  logic [IdxWidth-1:0]  s1_idx_q;
  logic [MetaWidth-1:0] s1_meta_q;

  logic [DataWidth-1:0] fifo_data_q [2];
  logic [MetaWidth-1:0] fifo_meta_q [2];
  logic [IdxWidth-1:0]  fifo_idx_q  [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;

  logic                 fifo_nonempty, pop, rd_ok;
  logic [IdxWidth-1:0]  head_idx;
  logic [1:0]           inflight;
  logic [NumInp-1:0]    eligible;
  logic                 gnt_valid;
  logic [IdxWidth-1:0]  gnt_idx;
  logic                 gnt_read;

  // Credit: reads in s1 or buffered, minus a same-cycle pop, must leave a free slot.
  always_comb begin
    fifo_nonempty = (count_q != 2'd0);
    head_idx      = fifo_idx_q[rd_ptr_q];
    pop           = fifo_nonempty & bus.resp_ready[head_idx];
    inflight      = {1'b0, s1_valid_q} + count_q;
    rd_ok         = (inflight - {1'b0, pop}) < 2'd2;
    eligible      = bus.req_valid & (bus.req_wen | {NumInp{rd_ok}});
  end

  // Round-robin scan starting at rr_ptr; nothing is granted while reset is asserted.
  always_comb begin
    logic [IdxWidth:0] cand;
    logic [IdxWidth:0] nxt;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumInp; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(k);
      if (cand >= (IdxWidth + 1)'(NumInp)) cand = cand - (IdxWidth + 1)'(NumInp);
      if (!gnt_valid && eligible[cand[IdxWidth-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxWidth-1:0];
      end
    end
    if (rst_i) gnt_valid = 1'b0;
    nxt = {1'b0, gnt_idx} + 1'b1;
    if (nxt == (IdxWidth + 1)'(NumInp)) nxt = '0;
    rr_ptr_d = nxt[IdxWidth-1:0];
    gnt_read = gnt_valid & ~bus.req_wen[gnt_idx];
  end

  // Grant and bank drive; bank fields are zeroed when idle.
  always_comb begin
    bus.req_ready  = '0;
    bus.bank_req   = gnt_valid;
    bus.bank_we    = 1'b0;
    bus.bank_addr  = '0;
    bus.bank_be    = '0;
    bus.bank_wdata = '0;
    if (gnt_valid) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.bank_we    = bus.req_wen[gnt_idx];
      bus.bank_addr  = bus.req_addr[gnt_idx*AddrMemWidth +: AddrMemWidth];
      bus.bank_be    = bus.req_be[gnt_idx*BeWidth +: BeWidth];
      bus.bank_wdata = bus.req_wdata[gnt_idx*DataWidth +: DataWidth];
    end
  end

  // Response port presents the FIFO head, one-hot on its requester index.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      bus.resp_valid[i] = fifo_nonempty & ~rst_i & (head_idx == IdxWidth'(i));
    end
    bus.resp_rdata = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    bus.resp_meta  = fifo_nonempty ? fifo_meta_q[rd_ptr_q] : '0;
  end

  // Arbitration pointer and the read-in-flight stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_meta_q  <= '0;
    end else begin
      if (gnt_valid) rr_ptr_q <= rr_ptr_d;
      s1_valid_q <= gnt_read;
      if (gnt_read) begin
        s1_idx_q  <= gnt_idx;
        s1_meta_q <= bus.req_meta[gnt_idx*MetaWidth +: MetaWidth];
      end
    end
  end

  // Response FIFO: push SRAM data the cycle after a read strobe, pop on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < 2; e++) begin
        fifo_data_q[e] <= '0;
        fifo_meta_q[e] <= '0;
        fifo_idx_q[e]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (s1_valid_q) begin
        fifo_data_q[wr_ptr_q] <= bus.bank_rdata;
        fifo_meta_q[wr_ptr_q] <= s1_meta_q;
        fifo_idx_q[wr_ptr_q]  <= s1_idx_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, s1_valid_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: a grant-order table plus hand-written sequences
// for read latency, credit backpressure, posted writes, contention and mid-run reset.
module tb_tcdm_bank_arbiter;
  localparam int unsigned NumInp = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcdm_bank_arbiter_if #(.NumInp(4), .DataWidth(32), .BeWidth(4), .AddrMemWidth(8),
                         .MetaWidth(8)) bus ();

  tcdm_bank_arbiter #(.NumInp(4), .DataWidth(32), .BeWidth(4), .AddrMemWidth(8),
                      .MetaWidth(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // SRAM model: 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.bank_req) begin
      if (bus.bank_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.bank_be[b]) mem[bus.bank_addr][8*b +: 8] <= bus.bank_wdata[8*b +: 8];
      end else begin
        bus.bank_rdata <= mem[bus.bank_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rdy;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [7:0] m);
    bus.req_valid[i]          = v;
    bus.req_wen[i]            = w;
    bus.req_addr[i*8 +: 8]    = a;
    bus.req_be[i*4 +: 4]      = 4'hF;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_meta[i*8 +: 8]    = m;
  endtask

  task automatic clr_req();
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    bus.req_meta  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge, away from the active edge.
  task automatic cyc(input string name, input logic [3:0] rdy, input logic [3:0] rv);
    @(negedge clk);
    chk({name, "_ready"}, {28'd0, bus.req_ready}, {28'd0, rdy});
    chk({name, "_rvalid"}, {28'd0, bus.resp_valid}, {28'd0, rv});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_req();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_addr;
    tbl[0]  = '{4'hF, 4'h1};
    tbl[1]  = '{4'hF, 4'h2};
    tbl[2]  = '{4'hF, 4'h4};
    tbl[3]  = '{4'hF, 4'h8};
    tbl[4]  = '{4'h6, 4'h2};
    tbl[5]  = '{4'h3, 4'h1};
    tbl[6]  = '{4'h8, 4'h8};
    tbl[7]  = '{4'h0, 4'h0};
    tbl[8]  = '{4'hA, 4'h2};
    tbl[9]  = '{4'h9, 4'h8};
    tbl[10] = '{4'h5, 4'h1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;
    mem[8'h40] = 32'hB000_0000;
    mem[8'h41] = 32'hB000_0001;
    mem[8'h50] = 32'hC000_0000;
    bus.bank_rdata = '0;
    bus.resp_ready = '1;

    // Reset state with every requester asking.
    clr_req();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 8'h33, 32'h1234_5678, 8'h77);
    step();
    @(negedge clk);
    chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_rvalid", {28'd0, bus.resp_valid}, 32'd0);
    chk("rst_bank_req", {31'd0, bus.bank_req}, 32'd0);
    chk("rst_bank_we", {31'd0, bus.bank_we}, 32'd0);
    chk("rst_bank_addr", {24'd0, bus.bank_addr}, 32'd0);
    chk("rst_bank_wdata", bus.bank_wdata, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    do_reset();

    // Grant-order table, writes only so credit never interferes.
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 4; i++)
        set_req(i, tbl[v].valid[i], 1'b1, 8'h20 + 8'(i), 32'h1000_0000 + i, 8'(i));
      exp_addr = 8'h0;
      for (int i = 0; i < 4; i++) if (tbl[v].exp_rdy[i]) exp_addr = 8'h20 + 8'(i);
      cyc($sformatf("tbl%0d", v), tbl[v].exp_rdy, 4'h0);
      chk($sformatf("tbl%0d_bank_req", v), {31'd0, bus.bank_req}, {31'd0, |tbl[v].exp_rdy});
      chk($sformatf("tbl%0d_bank_addr", v), {24'd0, bus.bank_addr}, {24'd0, exp_addr});
      step();
    end

    // Single read: requester 2, addr 0x10.
    do_reset();
    set_req(2, 1'b1, 1'b0, 8'h10, 32'h0, 8'h5A);
    cyc("rd_t0", 4'h4, 4'h0);
    chk("rd_t0_addr", {24'd0, bus.bank_addr}, 32'h10);
    chk("rd_t0_we", {31'd0, bus.bank_we}, 32'd0);
    step();
    clr_req();
    cyc("rd_t1", 4'h0, 4'h0);
    step();
    cyc("rd_t2", 4'h0, 4'h4);
    chk("rd_t2_data", bus.resp_rdata, 32'hCAFE_0001);
    chk("rd_t2_meta", {24'd0, bus.resp_meta}, 32'h5A);
    step();
    cyc("rd_t3", 4'h0, 4'h0);
    step();

    // Round-robin fairness: all four read for 8 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 8'(i), 32'h0, 8'h30 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      if (c == 8) clr_req();
      cyc($sformatf("rr%0d", c), (c < 8) ? 4'(1 << (c % 4)) : 4'h0,
          (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'h0);
      if (c >= 2) begin
        chk($sformatf("rr%0d_data", c), bus.resp_rdata, 32'hA000_0000 + ((c - 2) % 4));
        chk($sformatf("rr%0d_meta", c), {24'd0, bus.resp_meta}, 32'h30 + ((c - 2) % 4));
      end
      step();
    end

    // Response backpressure: two reads accepted, then stall until ready returns.
    do_reset();
    bus.resp_ready = '0;
    set_req(0, 1'b1, 1'b0, 8'h40, 32'h0, 8'h70);
    set_req(1, 1'b1, 1'b0, 8'h41, 32'h0, 8'h71);
    cyc("bp0", 4'h1, 4'h0); step();
    cyc("bp1", 4'h2, 4'h0); step();
    cyc("bp2", 4'h0, 4'h1); step();
    cyc("bp3", 4'h0, 4'h1); step();
    cyc("bp4", 4'h0, 4'h1);
    chk("bp4_data", bus.resp_rdata, 32'hB000_0000);
    step();
    bus.resp_ready = '1;
    cyc("bp5", 4'h1, 4'h1);
    chk("bp5_data", bus.resp_rdata, 32'hB000_0000);
    step();
    clr_req();
    cyc("bp6", 4'h0, 4'h2);
    chk("bp6_data", bus.resp_rdata, 32'hB000_0001);
    chk("bp6_meta", {24'd0, bus.resp_meta}, 32'h71);
    step();
    cyc("bp7", 4'h0, 4'h1);
    step();
    cyc("bp8", 4'h0, 4'h0);
    step();

    // Posted write with the credit exhausted.
    do_reset();
    bus.resp_ready = '0;
    set_req(0, 1'b1, 1'b0, 8'h50, 32'h0, 8'h80);
    cyc("wr0", 4'h1, 4'h0); step();
    cyc("wr1", 4'h1, 4'h0); step();
    set_req(3, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF, 8'h99);
    cyc("wr2", 4'h8, 4'h1);
    chk("wr2_we", {31'd0, bus.bank_we}, 32'd1);
    chk("wr2_addr", {24'd0, bus.bank_addr}, 32'h05);
    chk("wr2_wdata", bus.bank_wdata, 32'hDEAD_BEEF);
    chk("wr2_be", {28'd0, bus.bank_be}, 32'hF);
    step();
    clr_req();
    bus.resp_ready = '1;
    cyc("wr3", 4'h0, 4'h1); step();
    cyc("wr4", 4'h0, 4'h1); step();
    set_req(1, 1'b1, 1'b0, 8'h05, 32'h0, 8'h11);
    cyc("wr5", 4'h2, 4'h0); step();
    clr_req();
    cyc("wr6", 4'h0, 4'h0); step();
    cyc("wr7", 4'h0, 4'h2);
    chk("wr7_data", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("wr7_meta", {24'd0, bus.resp_meta}, 32'h11);
    step();

    // Mixed contention with rr_ptr at 1.
    do_reset();
    set_req(0, 1'b1, 1'b1, 8'h60, 32'h0000_0001, 8'h00);
    cyc("mx0", 4'h1, 4'h0); step();
    set_req(0, 1'b1, 1'b0, 8'h60, 32'h0, 8'h21);
    set_req(1, 1'b1, 1'b1, 8'h61, 32'h0000_0002, 8'h00);
    cyc("mx1", 4'h2, 4'h0);
    chk("mx1_we", {31'd0, bus.bank_we}, 32'd1);
    step();
    bus.req_valid[1] = 1'b0;
    cyc("mx2", 4'h1, 4'h0);
    chk("mx2_we", {31'd0, bus.bank_we}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'h68 + 8'(i), 32'h0, 8'h00);
    cyc("mx3", 4'h2, 4'h0); step();
    clr_req();
    cyc("mx4", 4'h0, 4'h1);
    chk("mx4_data", bus.resp_rdata, 32'h0000_0001);
    chk("mx4_meta", {24'd0, bus.resp_meta}, 32'h21);
    step();

    // Reset with two buffered responses.
    do_reset();
    bus.resp_ready = '0;
    set_req(0, 1'b1, 1'b0, 8'h70, 32'h0, 8'h44);
    cyc("mr0", 4'h1, 4'h0); step();
    cyc("mr1", 4'h1, 4'h0); step();
    cyc("mr2", 4'h0, 4'h1); step();
    clr_req();
    cyc("mr3", 4'h0, 4'h1);
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    chk("mr_rst_rvalid", {28'd0, bus.resp_valid}, 32'd0);
    chk("mr_rst_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("mr_rst_bank_req", {31'd0, bus.bank_req}, 32'd0);
    chk("mr_rst_rdata", bus.resp_rdata, 32'd0);
    step();
    rst = 1'b0;
    clr_req();
    bus.resp_ready = '1;
    for (int c = 0; c < 3; c++) begin
      cyc($sformatf("mr_post%0d", c), 4'h0, 4'h0);
      step();
    end
    set_req(1, 1'b1, 1'b0, 8'h10, 32'h0, 8'h01);
    set_req(2, 1'b1, 1'b0, 8'h10, 32'h0, 8'h02);
    cyc("mr_first", 4'h2, 4'h0);
    step();
    clr_req();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
